// File: rtl/apple_spawn_gen.sv
`default_nettype none
// ============================================================================
// Module   : apple_spawn_gen
// Brief    : LFSR-driven generator of a legal, registered apple spawn cell.
// Revision : 1.0 - initial release
// ============================================================================
module apple_spawn_gen #(
    parameter int          GRID_W = 64,
    parameter int          GRID_H = 48,
    parameter int          MARGIN = 1,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       freeze,
    input  logic [6:0] head_x,
    input  logic [5:0] head_y,
    input  logic [6:0] apple_x,
    input  logic [5:0] apple_y,
    output logic [6:0] x_start_grid,
    output logic [5:0] y_start_grid,
    output logic       pos_valid,
    output logic [7:0] reject_cnt
);

    localparam logic [15:0] c_TAPS  = 16'hB400;
    localparam logic [7:0]  c_X_MIN = 8'(MARGIN);
    localparam logic [7:0]  c_X_MAX = 8'(GRID_W - 1 - MARGIN);
    localparam logic [7:0]  c_Y_MIN = 8'(MARGIN);
    localparam logic [7:0]  c_Y_MAX = 8'(GRID_H - 1 - MARGIN);
    localparam logic [6:0]  c_X_RST = 7'(GRID_W / 4);
    localparam logic [5:0]  c_Y_RST = 6'(GRID_H / 4);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state, w_state_next;
    logic [15:0] r_lfsr, w_lfsr_next;
    logic [6:0]  r_x, w_x_next;
    logic [5:0]  r_y, w_y_next;
    logic        r_valid, w_valid_next;
    logic [7:0]  r_rcnt, w_rcnt_next;

    logic [6:0]  w_cx;
    logic [5:0]  w_cy;
    logic [7:0]  w_cx8, w_cy8;
    logic        w_in_bounds;
    logic        w_hit_head;
    logic        w_hit_apple;
    logic        w_accept;

    assign w_cx  = r_lfsr[6:0];
    assign w_cy  = r_lfsr[13:8];
    assign w_cx8 = {1'b0, w_cx};
    assign w_cy8 = {2'b00, w_cy};

    assign w_in_bounds = (w_cx8 >= c_X_MIN) && (w_cx8 <= c_X_MAX) &&
                         (w_cy8 >= c_Y_MIN) && (w_cy8 <= c_Y_MAX);
    assign w_hit_head  = (w_cx == head_x)  && (w_cy == head_y);
    assign w_hit_apple = (w_cx == apple_x) && (w_cy == apple_y);
    assign w_accept    = w_in_bounds && !w_hit_head && !w_hit_apple;

    // All-zero is a lock-up state of the LFSR; recover by reloading the seed.
    always_comb begin
        if (r_lfsr == 16'h0000) begin
            w_lfsr_next = SEED;
        end else begin
            w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_TAPS : 16'h0000);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_x;
        w_y_next     = r_y;
        w_valid_next = r_valid;
        w_rcnt_next  = r_rcnt;
        case (r_state)
            ST_INIT: begin
                if (w_accept) begin
                    w_x_next     = w_cx;
                    w_y_next     = w_cy;
                    w_valid_next = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!freeze) begin
                    if (w_accept) begin
                        w_x_next    = w_cx;
                        w_y_next    = w_cy;
                        w_rcnt_next = 8'd0;
                    end else if (r_rcnt != 8'hFF) begin
                        w_rcnt_next = r_rcnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INIT;
            r_lfsr  <= SEED;
            r_x     <= c_X_RST;
            r_y     <= c_Y_RST;
            r_valid <= 1'b0;
            r_rcnt  <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_lfsr  <= w_lfsr_next;
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_valid <= w_valid_next;
            r_rcnt  <= w_rcnt_next;
        end
    end

    assign x_start_grid = r_x;
    assign y_start_grid = r_y;
    assign pos_valid    = r_valid;
    assign reject_cnt   = r_rcnt;

endmodule
`default_nettype wire

// File: tb/tb_apple_spawn_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_apple_spawn_gen
// Brief    : Scoreboard bench for apple_spawn_gen against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apple_spawn_gen;

    localparam logic [15:0] c_SEED = 16'hACE1;

    logic       clk;
    logic       reset;
    logic       freeze;
    logic [6:0] head_x;
    logic [5:0] head_y;
    logic [6:0] apple_x;
    logic [5:0] apple_y;
    logic [6:0] x_start_grid;
    logic [5:0] y_start_grid;
    logic       pos_valid;
    logic [7:0] reject_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [6:0] x;
        logic [5:0] y;
        logic       v;
        logic [7:0] rc;
    } exp_t;

    exp_t q_exp[$];

    // Behavioural reference state
    logic [15:0] m_lfsr;
    logic [6:0]  m_x;
    logic [5:0]  m_y;
    logic        m_v;
    logic [7:0]  m_rc;
    logic        m_run;

    logic [6:0]  rec_x[40];
    logic [5:0]  rec_y[40];

    apple_spawn_gen #(
        .GRID_W (64),
        .GRID_H (48),
        .MARGIN (1),
        .SEED   (c_SEED)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .freeze       (freeze),
        .head_x       (head_x),
        .head_y       (head_y),
        .apple_x      (apple_x),
        .apple_y      (apple_y),
        .x_start_grid (x_start_grid),
        .y_start_grid (y_start_grid),
        .pos_valid    (pos_valid),
        .reject_cnt   (reject_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr = c_SEED;
        m_x    = 7'd16;
        m_y    = 6'd12;
        m_v    = 1'b0;
        m_rc   = 8'd0;
        m_run  = 1'b0;
    endtask

    function automatic logic model_accept(input logic [6:0] hx, input logic [5:0] hy,
                                          input logic [6:0] ax, input logic [5:0] ay);
        logic [6:0] cx;
        logic [5:0] cy;
        cx = m_lfsr[6:0];
        cy = m_lfsr[13:8];
        return (cx >= 7'd1) && (cx <= 7'd62) && (cy >= 6'd1) && (cy <= 6'd46) &&
               !(cx == hx && cy == hy) && !(cx == ax && cy == ay);
    endfunction

    task automatic model_tick(input logic [6:0] hx, input logic [5:0] hy,
                              input logic [6:0] ax, input logic [5:0] ay, input logic frz);
        logic acc;
        acc = model_accept(hx, hy, ax, ay);
        if (!m_run) begin
            if (acc) begin
                m_x = m_lfsr[6:0];
                m_y = m_lfsr[13:8];
                m_v = 1'b1;
                m_run = 1'b1;
            end
        end else if (!frz) begin
            if (acc) begin
                m_x  = m_lfsr[6:0];
                m_y  = m_lfsr[13:8];
                m_rc = 8'd0;
            end else if (m_rc != 8'd255) begin
                m_rc = m_rc + 8'd1;
            end
        end
        if (m_lfsr == 16'h0000) m_lfsr = c_SEED;
        else if (m_lfsr[0])     m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
        else                    m_lfsr = m_lfsr >> 1;
    endtask

    // Called at a falling edge: drive, predict, wait one rising edge, compare.
    task automatic step(input logic [6:0] hx, input logic [5:0] hy,
                        input logic [6:0] ax, input logic [5:0] ay, input logic frz);
        exp_t e;
        head_x  = hx;
        head_y  = hy;
        apple_x = ax;
        apple_y = ay;
        freeze  = frz;
        model_tick(hx, hy, ax, ay, frz);
        e.x = m_x; e.y = m_y; e.v = m_v; e.rc = m_rc;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        e = q_exp.pop_front();
        check("x_start_grid", int'(x_start_grid), int'(e.x));
        check("y_start_grid", int'(y_start_grid), int'(e.y));
        check("pos_valid",    int'(pos_valid),    int'(e.v));
        check("reject_cnt",   int'(reject_cnt),   int'(e.rc));
        @(negedge clk);
    endtask

    initial begin
        int first_valid;
        logic [6:0] sx;
        logic [5:0] sy;
        logic [7:0] src;
        logic [6:0] hx;
        logic [5:0] hy;

        reset = 1'b0; freeze = 1'b0;
        head_x = '0; head_y = '0; apple_x = 7'd32; apple_y = 6'd24;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_x",  int'(x_start_grid), 16);
        check("rst_y",  int'(y_start_grid), 12);
        check("rst_v",  int'(pos_valid),    0);
        check("rst_rc", int'(reject_cnt),   0);
        reset = 1'b1;

        // Startup: first accept must come quickly and be inside the margins
        first_valid = -1;
        for (int i = 0; i < 40; i++) begin
            step(7'd0, 6'd0, 7'd32, 6'd24, 1'b0);
            rec_x[i] = m_x;
            rec_y[i] = m_y;
            if (first_valid < 0 && pos_valid) first_valid = i;
        end
        check("valid_within_8", int'(first_valid >= 0 && first_valid < 8), 1);
        check("x_in_bounds", int'(x_start_grid >= 7'd1 && x_start_grid <= 7'd62), 1);
        check("y_in_bounds", int'(y_start_grid >= 6'd1 && y_start_grid <= 6'd46), 1);

        // Apple feedback from the model outputs, random head with frequent eat events
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                hx = m_x; hy = m_y;
            end else begin
                hx = 7'($urandom_range(0, 63));
                hy = 6'($urandom_range(0, 47));
            end
            step(hx, hy, m_x, m_y, 1'b0);
        end

        // Head and apple parked on an in-bounds candidate: forced rejection
        for (int i = 0; i < 200 && !model_accept(7'd0, 6'd0, 7'd0, 6'd0); i++)
            step(7'd0, 6'd0, 7'd0, 6'd0, 1'b0);
        sx = x_start_grid; sy = y_start_grid; src = m_rc;
        step(m_lfsr[6:0], m_lfsr[13:8], m_lfsr[6:0], m_lfsr[13:8], 1'b0);
        check("collide_x_hold", int'(x_start_grid), int'(sx));
        check("collide_y_hold", int'(y_start_grid), int'(sy));
        check("collide_rc_inc", int'(reject_cnt), int'(src) + 1);

        // Every candidate blocked long enough to saturate the reject counter
        for (int i = 0; i < 300; i++)
            step(m_lfsr[6:0], m_lfsr[13:8], m_lfsr[6:0], m_lfsr[13:8], 1'b0);
        check("rc_saturate", int'(reject_cnt), 255);

        // Freeze holds everything for 1000 cycles
        sx = m_x; sy = m_y; src = m_rc;
        for (int i = 0; i < 1000; i++)
            step(7'($urandom_range(0, 63)), 6'($urandom_range(0, 47)), 7'd0, 6'd0, 1'b1);
        check("freeze_x",  int'(x_start_grid), int'(sx));
        check("freeze_y",  int'(y_start_grid), int'(sy));
        check("freeze_rc", int'(reject_cnt),   int'(src));
        for (int i = 0; i < 20; i++)
            step(7'd0, 6'd0, 7'd32, 6'd24, 1'b0);

        // Asynchronous reset mid-run, then replay the startup sequence
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst_x", int'(x_start_grid), 16);
        check("midrst_y", int'(y_start_grid), 12);
        check("midrst_v", int'(pos_valid),    0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(7'd0, 6'd0, 7'd32, 6'd24, 1'b0);
            check("rerun_x", int'(x_start_grid), int'(rec_x[i]));
            check("rerun_y", int'(y_start_grid), int'(rec_y[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
